branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver_pkg.sv | 42 ++++
 rtl/branch_resolver_bht.sv | 54 +++++
 rtl/branch_resolver.sv | 136 +++++++++++++
 tb/tb_branch_resolver.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolver_pkg
// Shared definitions for the branch resolver: jump opcodes, FSM state type,
// BHT counter reset value and opcode decode helpers.
// -----------------------------------------------------------------------------
package branch_resolver_pkg;

  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZE = 3'b101;
  localparam logic [2:0] OP_JNE = 3'b110;
  localparam logic [2:0] OP_JCY = 3'b111;

  // Weakly not taken
  localparam logic [1:0] CTR_RST = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Only the three conditional jumps train or consult the BHT
  function automatic logic is_cond(input logic [2:0] op);
    return (op == OP_JZE) || (op == OP_JNE) || (op == OP_JCY);
  endfunction

  // Actual branch outcome; anything that is not a conditional jump resolves
  // as not taken
  function automatic logic branch_taken(input logic [2:0] op,
                                        input logic       zero,
                                        input logic       carry);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_JZE:  taken = zero;
      OP_JNE:  taken = !zero;
      OP_JCY:  taken = carry;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_resolver_bht.sv
// -----------------------------------------------------------------------------
// branch_bht
// Branch history table of 2-bit saturating counters.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (counters -> CTR_RST)
//   i_rd_idx       : lookup index
//   o_rd_taken     : prediction (counter MSB), forwarded from a same-cycle write
//   i_wr_en        : update strobe
//   i_wr_idx       : index to update
//   i_wr_taken     : actual outcome (1: count up, 0: count down)
// -----------------------------------------------------------------------------
module branch_bht
  import branch_resolver_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_taken,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0] r_ctr [0:ENTRIES-1];
  logic [1:0] w_cur;
  logic [1:0] w_upd;

  assign w_cur = r_ctr[i_wr_idx];

  always_comb begin
    w_upd = w_cur;
    if (i_wr_taken) begin
      if (w_cur != 2'b11) w_upd = w_cur + 2'd1;
    end else begin
      if (w_cur != 2'b00) w_upd = w_cur - 2'd1;
    end
  end

  // Write-through: a lookup hitting the entry being updated sees the new value
  assign o_rd_taken = (i_wr_en && (i_wr_idx == i_rd_idx)) ? w_upd[1]
                                                          : r_ctr[i_rd_idx][1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < ENTRIES; k++) r_ctr[k] <= CTR_RST;
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= w_upd;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
// Predicts conditional jumps (JZE/JNE/JCY), holds one pending branch until the
// ALU flags arrive, then resolves it and raises a one-cycle flush with the
// corrected fetch address on a misprediction.
//   clk, rst_n    : clock, asynchronous active-low reset
//   enable        : conditional jump present on I, prediction requested
//   I             : instruction ([21:19] opcode, [10:0] target)
//   PC            : address of the instruction on I
//   flags_valid   : zero/carry valid for the pending branch
//   zero, carry   : ALU flags
//   predict_taken : registered prediction of the accepted branch
//   pred_next     : predicted fetch address (target or PC+1)
//   busy          : a branch awaits resolution
//   flush         : one-cycle misprediction pulse
//   next          : corrected fetch address, valid while flush = 1
// Configuration: define BRANCH_RESOLVER_BHT_EN to enable the 2-bit counter BHT;
// otherwise every branch is predicted not taken.
// -----------------------------------------------------------------------------
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [21:0] I,
  input  logic [10:0] PC,
  input  logic        flags_valid,
  input  logic        zero,
  input  logic        carry,
  output logic        predict_taken,
  output logic [10:0] pred_next,
  output logic        busy,
  output logic        flush,
  output logic [10:0] next
);

  state_e      r_state;
  logic [2:0]  r_op;
  logic [10:0] r_tgt;
  logic [10:0] r_pc;
  logic        r_pt;
  logic [10:0] r_pred_next;
  logic        r_flush;
  logic [10:0] r_next;

  logic        w_resolve;
  logic        w_actual;
  logic        w_mispredict;
  logic        w_accept;
  logic        w_pred;
  logic [10:0] w_pc_inc;
  logic [10:0] w_lat_pc_inc;
  logic        w_unused_ibits;

  assign w_unused_ibits = ^I[18:11];

  assign w_resolve    = (r_state == ST_PEND) && flags_valid;
  assign w_actual     = branch_taken(r_op, zero, carry);
  assign w_mispredict = w_resolve && (w_actual != r_pt);
  // A new branch is taken in when idle, or back-to-back behind a correctly
  // predicted one; a mispredict cycle drops it as wrong-path.
  assign w_accept     = enable &&
                        ((r_state == ST_IDLE) || (w_resolve && !w_mispredict));
  // 11-bit adders wrap modulo 2048 naturally
  assign w_pc_inc     = PC + 11'd1;
  assign w_lat_pc_inc = r_pc + 11'd1;

`ifdef BRANCH_RESOLVER_BHT_EN
  logic w_bht_taken;

  branch_bht #(
    .IDX_W(BHT_IDX_W)
  ) u_bht (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rd_idx   (PC[BHT_IDX_W-1:0]),
    .o_rd_taken (w_bht_taken),
    .i_wr_en    (w_resolve && is_cond(r_op)),
    .i_wr_idx   (r_pc[BHT_IDX_W-1:0]),
    .i_wr_taken (w_actual)
  );

  assign w_pred = is_cond(I[21:19]) && w_bht_taken;
`else
  assign w_pred = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= 3'b000;
      r_tgt       <= 11'h000;
      r_pc        <= 11'h000;
      r_pt        <= 1'b0;
      r_pred_next <= 11'h000;
      r_flush     <= 1'b0;
      r_next      <= 11'h000;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_PEND;
        end
        ST_PEND: begin
          if (flags_valid) begin
            if (w_mispredict) begin
              r_flush <= 1'b1;
              r_next  <= w_actual ? r_tgt : w_lat_pc_inc;
              r_state <= ST_IDLE;
            end else if (!enable) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_accept) begin
        r_op        <= I[21:19];
        r_tgt       <= I[10:0];
        r_pc        <= PC;
        r_pt        <= w_pred;
        r_pred_next <= w_pred ? I[10:0] : w_pc_inc;
      end
    end
  end

  assign predict_taken = r_pt;
  assign pred_next     = r_pred_next;
  assign busy          = (r_state == ST_PEND);
  assign flush         = r_flush;
  assign next          = r_next;

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
// Directed bench for branch_resolver with a behavioural reference model.
// Follows BRANCH_RESOLVER_BHT_EN to pick the predictor the model emulates.
// -----------------------------------------------------------------------------
module tb_branch_resolver;

`ifdef BRANCH_RESOLVER_BHT_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif
  localparam int ENTRIES = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [21:0] I = '0;
  logic [10:0] PC = '0;
  logic        flags_valid = 1'b0;
  logic        zero = 1'b0;
  logic        carry = 1'b0;
  logic        predict_taken;
  logic [10:0] pred_next;
  logic        busy;
  logic        flush;
  logic [10:0] next;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  branch_resolver #(.BHT_IDX_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .I             (I),
    .PC            (PC),
    .flags_valid   (flags_valid),
    .zero          (zero),
    .carry         (carry),
    .predict_taken (predict_taken),
    .pred_next     (pred_next),
    .busy          (busy),
    .flush         (flush),
    .next          (next)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int bht [ENTRIES];
  bit m_busy = 0, m_pt = 0, m_flush = 0;
  int m_pn = 0, m_next = 0;
  int l_op = 0, l_tgt = 0, l_pc = 0;
  bit acc, act;
  int op_in;

  function automatic bit outcome(int op, bit z, bit c);
    if (op == 5) return z;
    if (op == 6) return !z;
    if (op == 7) return c;
    return 1'b0;
  endfunction

  function automatic bit conditional(int op);
    return (op >= 5) && (op <= 7);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_pt = 0; m_flush = 0; m_pn = 0; m_next = 0;
      for (int k = 0; k < ENTRIES; k++) bht[k] = 1;
    end else begin
      acc = 0;
      m_flush = 0;
      if (!m_busy) acc = enable;
      else if (flags_valid) begin
        act = outcome(l_op, zero, carry);
        if (B && conditional(l_op)) begin
          if (act) bht[l_pc % ENTRIES] = (bht[l_pc % ENTRIES] < 3) ? bht[l_pc % ENTRIES] + 1 : 3;
          else     bht[l_pc % ENTRIES] = (bht[l_pc % ENTRIES] > 0) ? bht[l_pc % ENTRIES] - 1 : 0;
        end
        if (act != m_pt) begin
          m_flush = 1;
          m_next = act ? l_tgt : (l_pc + 1) % 2048;
          m_busy = 0;
        end else if (enable) acc = 1;
        else m_busy = 0;
      end
      if (acc) begin
        op_in = int'(I[21:19]);
        m_pt = B && conditional(op_in) && (bht[int'(PC) % ENTRIES] >= 2);
        m_pn = m_pt ? int'(I[10:0]) : (int'(PC) + 1) % 2048;
        l_op = op_in; l_tgt = int'(I[10:0]); l_pc = int'(PC);
        m_busy = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (armed && rst_n) begin
      chk("m_busy", int'(busy), int'(m_busy));
      chk("m_predict_taken", int'(predict_taken), int'(m_pt));
      chk("m_pred_next", int'(pred_next), m_pn);
      chk("m_flush", int'(flush), int'(m_flush));
      if (m_flush) chk("m_next", int'(next), m_next);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [10:0] pc, input logic [10:0] tgt);
    enable = 1'b1; I = {op, 8'h00, tgt}; PC = pc;
    tick();
    enable = 1'b0;
  endtask

  task automatic resolve(input logic z, input logic c);
    flags_valid = 1'b1; zero = z; carry = c;
    tick();
    flags_valid = 1'b0;
  endtask

  task automatic resolve_with(input logic z, input logic c, input logic [2:0] op,
                              input logic [10:0] pc, input logic [10:0] tgt);
    flags_valid = 1'b1; zero = z; carry = c;
    enable = 1'b1; I = {op, 8'h00, tgt}; PC = pc;
    tick();
    flags_valid = 1'b0; enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    armed = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_flush", int'(flush), 0);
    chk("rst_predict_taken", int'(predict_taken), 0);
    chk("rst_pred_next", int'(pred_next), 0);
    chk("rst_next", int'(next), 0);
    tick();
    #2 rst_n = 1'b1;
    tick();

    // JZE training at PC 0x010 (BHT index 0)
    issue(3'b101, 11'h010, 11'h200);
    chk("i1_pt", int'(predict_taken), 0);
    chk("i1_pred_next", int'(pred_next), 'h011);
    chk("i1_busy", int'(busy), 1);
    resolve(1'b1, 1'b0);
    chk("i1_flush", int'(flush), 1);
    chk("i1_next", int'(next), 'h200);
    chk("i1_busy_after", int'(busy), 0);
    tick();
    chk("i1_flush_pulse", int'(flush), 0);

    issue(3'b101, 11'h010, 11'h200);
    chk("i2_pt", int'(predict_taken), int'(B));
    chk("i2_pred_next", int'(pred_next), B ? 'h200 : 'h011);
    resolve(1'b1, 1'b0);
    chk("i2_flush", int'(flush), int'(!B));

    issue(3'b101, 11'h010, 11'h200);
    chk("i3_pt", int'(predict_taken), int'(B));
    resolve(1'b1, 1'b0);
    chk("i3_flush", int'(flush), int'(!B));

    issue(3'b101, 11'h010, 11'h200);
    resolve(1'b1, 1'b0);
    // Saturated at 3: one not-taken step leaves it predicting taken
    issue(3'b101, 11'h010, 11'h200);
    chk("sat_pt", int'(predict_taken), int'(B));
    resolve(1'b0, 1'b0);
    chk("sat_flush", int'(flush), int'(B));
    issue(3'b101, 11'h010, 11'h200);
    chk("sat2_pt", int'(predict_taken), int'(B));
    resolve(1'b1, 1'b0);

    // JCY at the top of the address space
    issue(3'b111, 11'h7FF, 11'h123);
    resolve(1'b0, 1'b1);
    issue(3'b111, 11'h7FF, 11'h123);
    resolve(1'b0, 1'b1);
    issue(3'b111, 11'h7FF, 11'h123);
    chk("jcy_pt", int'(predict_taken), int'(B));
    chk("jcy_pred_next", int'(pred_next), B ? 'h123 : 'h000);
    resolve(1'b0, 1'b0);
    chk("jcy_flush", int'(flush), int'(B));

    // Correct JNE with back-to-back JZE
    issue(3'b110, 11'h021, 11'h0AA);
    chk("jne_pt", int'(predict_taken), 0);
    resolve_with(1'b1, 1'b0, 3'b101, 11'h031, 11'h155);
    chk("b2b_flush", int'(flush), 0);
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_pt", int'(predict_taken), 0);
    chk("b2b_pred_next", int'(pred_next), 'h032);
    resolve(1'b0, 1'b0);
    chk("b2b_done_flush", int'(flush), 0);
    chk("b2b_done_busy", int'(busy), 0);

    // Mispredict drops the simultaneous enable
    issue(3'b101, 11'h045, 11'h300);
    resolve_with(1'b1, 1'b0, 3'b101, 11'h046, 11'h111);
    chk("drop_flush", int'(flush), 1);
    chk("drop_next", int'(next), 'h300);
    chk("drop_busy", int'(busy), 0);
    tick();
    chk("drop_busy2", int'(busy), 0);

    // Non-conditional opcode at a strongly-taken index
    issue(3'b100, 11'h050, 11'h3AA);
    chk("unk_pt", int'(predict_taken), 0);
    chk("unk_pred_next", int'(pred_next), 'h051);
    chk("unk_busy", int'(busy), 1);
    resolve(1'b1, 1'b1);
    chk("unk_flush", int'(flush), 0);
    chk("unk_busy_after", int'(busy), 0);

    // Asynchronous reset while pending
    issue(3'b101, 11'h010, 11'h200);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_flush", int'(flush), 0);
    chk("mid_rst_pt", int'(predict_taken), 0);
    chk("mid_rst_pred_next", int'(pred_next), 0);
    chk("mid_rst_next", int'(next), 0);
    #2 rst_n = 1'b1;
    tick();
    issue(3'b101, 11'h010, 11'h200);
    chk("post_rst_pt", int'(predict_taken), 0);
    chk("post_rst_pred_next", int'(pred_next), 'h011);
    resolve(1'b1, 1'b0);
    chk("post_rst_flush", int'(flush), 1);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
